// File: rtl/tt_uio_uart_tx.sv
// Byte-wide UART transmitter: valid/ready write port, small FIFO, 8N1 LSB-first serialiser on a uio pin.
// Optional even parity bit between data and stop when TT_UART_TX_PARITY_EN is defined.
module tt_uio_uart_tx #(
  parameter int DIV        = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          tx_oe,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CNT_W = $clog2(DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef TT_UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push, pop, full, cnt_zero, can_pop;
  logic [7:0]       head;
`ifdef TT_UART_TX_PARITY_EN
  logic             parity_q;
`endif

  assign full     = (level_q == LVL_MAX);
  assign wr_ready = ena && !full;
  assign push     = wr_valid && wr_ready;
  assign head     = mem[rd_ptr_q[PTR_W-1:0]];
  assign cnt_zero = (cnt_q == '0);
  assign can_pop  = ena && (level_q != '0);

  assign tx    = tx_q;
  assign tx_oe = ena;
  assign busy  = (state_q != ST_IDLE);
  assign level = level_q;

  // Frame sequencer: every state/bit entry reloads the baud counter, advance on zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (can_pop) begin
          pop     = 1'b1;
          state_d = ST_START;
          cnt_d   = DIV_M1;
          shreg_d = head;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_zero) begin
          state_d = ST_DATA;
          cnt_d   = DIV_M1;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_zero) begin
          cnt_d = DIV_M1;
          if (bit_q == 3'd7) begin
`ifdef TT_UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef TT_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt_zero) begin
          state_d = ST_STOP;
          cnt_d   = DIV_M1;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_zero) begin
          cnt_d = DIV_M1;
          if (can_pop) begin
            pop     = 1'b1;
            state_d = ST_START;
            shreg_d = head;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Byte storage and shifter carry no reset; they are qualified by the control state.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PTR_W-1:0]] <= wr_data;
    shreg_q <= shreg_d;
`ifdef TT_UART_TX_PARITY_EN
    if (pop) parity_q <= ^head;
`endif
  end

endmodule

// File: tb/tb_tt_uio_uart_tx.sv
// Bench for tt_uio_uart_tx: two instances (DIV=4 and DIV=2) against a waveform-level reference model.
module tb_tt_uio_uart_tx;

  localparam int DEPTH = 4;
`ifdef TT_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready0, tx0, tx_oe0, busy0;
  logic       wr_ready1, tx1, tx_oe1, busy1;
  logic [2:0] level0, level1;

  always #5 clk = ~clk;

  tt_uio_uart_tx #(.DIV(4), .FIFO_DEPTH(DEPTH)) u_div4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready0), .tx(tx0), .tx_oe(tx_oe0), .busy(busy0), .level(level0)
  );

  tt_uio_uart_tx #(.DIV(2), .FIFO_DEPTH(DEPTH)) u_div2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready1), .tx(tx1), .tx_oe(tx_oe1), .busy(busy1), .level(level1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents plus the remaining cycles of the frame on the line.
  int          rem [2];
  int          fcnt [2];
  logic [10:0] fbits [2];
  logic [7:0]  fmem [2][DEPTH];

  int cyc = 0;
  int bcnt0, first0, last0, bcnt1, first1, last1, max_lvl0;
  bit acc0;

  function automatic int divof(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic exp_tx(int i);
    int idx;
    if (rem[i] == 0) return 1'b1;
    idx = (NBITS * divof(i) - rem[i]) / divof(i);
    return fbits[i][idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rem[i]  = 0;
      fcnt[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int lvl;
    bit do_push, do_pop;
    logic [7:0] b;
    if (!rst_n) begin
      rem[i]  = 0;
      fcnt[i] = 0;
      return;
    end
    lvl     = fcnt[i];
    do_push = wr_valid && ena && (lvl < DEPTH);
    do_pop  = (rem[i] <= 1) && ena && (lvl != 0);
    if (rem[i] > 0) rem[i]--;
    if (do_pop) begin
      b = fmem[i][0];
      for (int k = 0; k < DEPTH - 1; k++) fmem[i][k] = fmem[i][k+1];
      fcnt[i]--;
`ifdef TT_UART_TX_PARITY_EN
      fbits[i] = {1'b1, ^b, b, 1'b0};
`else
      fbits[i] = {1'b0, 1'b1, b, 1'b0};
`endif
      rem[i] = NBITS * divof(i);
    end
    if (do_push) begin
      fmem[i][fcnt[i]] = wr_data;
      fcnt[i]++;
    end
  endtask

  task automatic clear_meas();
    bcnt0 = 0; first0 = -1; last0 = -1;
    bcnt1 = 0; first1 = -1; last1 = -1;
    max_lvl0 = 0;
  endtask

  task automatic step();
    #1;
    check("wr_ready0", wr_ready0, ena && (fcnt[0] < DEPTH));
    check("wr_ready1", wr_ready1, ena && (fcnt[1] < DEPTH));
    check("tx_oe0", tx_oe0, ena);
    check("tx_oe1", tx_oe1, ena);
    acc0 = wr_valid && wr_ready0;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cyc++;
    check("tx0", tx0, exp_tx(0));
    check("tx1", tx1, exp_tx(1));
    check("busy0", busy0, rem[0] != 0);
    check("busy1", busy1, rem[1] != 0);
    check("level0", level0, fcnt[0]);
    check("level1", level1, fcnt[1]);
    if (busy0) begin
      bcnt0++;
      if (first0 < 0) first0 = cyc;
      last0 = cyc;
    end
    if (busy1) begin
      bcnt1++;
      if (first1 < 0) first1 = cyc;
      last1 = cyc;
    end
    if (int'(level0) > max_lvl0) max_lvl0 = int'(level0);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write1(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(!busy0 && !busy1 && level0 == 3'd0 && level1 == 3'd0) && n < limit) begin
      step();
      n++;
    end
    check("idle_timeout", n < limit, 1'b1);
  endtask

  initial begin
    model_reset();
    clear_meas();

    // Reset state
    run(3);
    check("rst_tx0", tx0, 1'b1);
    check("rst_level0", level0, 3'd0);
    rst_n = 1'b1;
    ena   = 1'b1;
    run(2);

    // Single frame 0xA5
    clear_meas();
    write1(8'hA5);
    wait_idle(200);
    check("a5_busy_cycles0", bcnt0, NBITS * 4);
    check("a5_busy_cycles1", bcnt1, NBITS * 2);
    check("a5_contig0", last0 - first0 + 1, bcnt0);
    run(3);

    // Burst 0x01..0x06 with hold on back-pressure
    clear_meas();
    begin
      int d = 1;
      int n = 0;
      wr_valid = 1'b1;
      while (d <= 6 && n < 300) begin
        wr_data = 8'(d);
        step();
        if (acc0) d++;
        n++;
      end
      wr_valid = 1'b0;
      check("burst_accept_timeout", n < 300, 1'b1);
    end
    wait_idle(800);
    check("burst_level_peak", max_lvl0, DEPTH);
    check("burst_busy_cycles0", bcnt0, 6 * NBITS * 4);
    check("burst_contig0", last0 - first0 + 1, bcnt0);
    run(3);

    // ena drop mid-frame with bytes queued
    write1(8'h11);
    write1(8'h22);
    write1(8'h33);
    run(15);
    ena = 1'b0;
    run(80);
    check("ena_off_level0", level0, 3'd2);
    check("ena_off_tx0", tx0, 1'b1);
    check("ena_off_oe0", tx_oe0, 1'b0);
    check("ena_off_busy0", busy0, 1'b0);
    ena = 1'b1;
    wait_idle(400);
    run(3);

    // Asynchronous reset during data bit 3 of 0xF0
    write1(8'hF0);
    write1(8'h3C);
    write1(8'h5A);
    run(17);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_tx0", tx0, 1'b1);
    check("async_rst_busy0", busy0, 1'b0);
    check("async_rst_level0", level0, 3'd0);
    check("async_rst_level1", level1, 3'd0);
    run(2);
    rst_n = 1'b1;
    run(30);
    check("post_rst_tx0", tx0, 1'b1);
    check("post_rst_busy0", busy0, 1'b0);

    // Minimum divisor: 0xFF, 0x00 back to back
    clear_meas();
    write1(8'hFF);
    write1(8'h00);
    wait_idle(300);
    check("div2_busy_cycles1", bcnt1, 2 * NBITS * 2);
    check("div2_contig1", last1 - first1 + 1, bcnt1);
    run(3);

    // Parity-relevant bytes
    clear_meas();
    write1(8'h07);
    wait_idle(200);
    check("b07_busy_cycles0", bcnt0, NBITS * 4);
    clear_meas();
    write1(8'h03);
    wait_idle(200);
    check("b03_busy_cycles0", bcnt0, NBITS * 4);

    // Randomised traffic with ena toggling
    for (int k = 0; k < 800; k++) begin
      wr_valid = ($urandom_range(0, 9) < 4);
      wr_data  = 8'($urandom);
      if ($urandom_range(0, 99) < 3) ena = ~ena;
      step();
    end
    wr_valid = 1'b0;
    ena      = 1'b1;
    wait_idle(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tt_uio_uart_tx.md
Name: tt_uio_uart_tx

Overview:
- Byte-oriented UART transmitter for the Tiny Tapeout user area.
- Takes bytes from the dedicated inputs through a valid/ready write port.
- Buffers them in a small FIFO and serialises them 8N1, LSB first, onto a bidirectional uio pin.
- Drives that pin as an output (uio_oe bit high) whenever the design is enabled.

Parameters:
- DIV, 104, clock cycles per UART bit; legal range 2..65535; counter width derived from DIV.
- FIFO_DEPTH, 4, byte entries in the write FIFO; power of two, 2..16.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  tile enable; gates new writes and new frame starts
- wr_data  input  8  byte to transmit
- wr_valid  input  1  wr_data valid this cycle
- wr_ready  output  1  FIFO can accept; combinational: ena && !full
- tx  output  1  serial line, idle high, registered
- tx_oe  output  1  output enable for the tx uio bit; combinational: equals ena
- busy  output  1  frame in progress (FSM not IDLE), registered
- level  output  clog2(FIFO_DEPTH)+1  FIFO occupancy, registered

Behaviour:
- Reset (async, rst_n low):
  - tx=1, busy=0, level=0; FIFO pointers cleared; FSM=IDLE; bit counter and baud counter cleared.
  - Takes effect immediately, including mid-frame; tx returns high without finishing the frame.
  - Queued bytes are discarded.
- Write:
  - A byte is accepted at the rising edge where wr_valid && wr_ready.
  - Writes while wr_ready=0 are dropped; the source must hold the byte.
  - Pop and write in the same edge leave level unchanged.
  - When full, wr_ready=0 and no overwrite occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If ena && level!=0, pop the head byte into the shift register at the next edge and enter START.
  - START: tx=0 for DIV cycles.
  - DATA: 8 bits, shift register LSB first, each bit DIV cycles; 3-bit counter 0..7.
  - STOP: tx=1 for DIV cycles.
  - At the last cycle of STOP: if ena && level!=0, pop and go directly to START with no idle gap; else go to IDLE.
- Baud counter:
  - Loads DIV-1 on each state/bit entry and decrements to 0.
  - The bit advances on the cycle the counter equals 0.
  - Every bit lasts exactly DIV cycles; a frame lasts exactly 10*DIV cycles.
- Latency: a byte written at edge E into an empty FIFO with FSM idle is popped at edge E+1; tx falls after edge E+1.
- busy: 1 from the START entry edge until the edge returning to IDLE.
- ena low:
  - No new frame starts and writes are blocked.
  - A frame already in progress completes normally.
  - Queued bytes are retained.
  - tx_oe drops to 0 immediately, so the pad floats; tx is still driven internally.
- level is never greater than FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty distinction.

Optional Feature:
- Macro: TT_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even parity bit (XOR of the 8 data bits) for DIV cycles.
  - Frame becomes 11*DIV cycles.
- Undefined: no PARITY state; frames are 8N1, 10*DIV cycles; no parity logic synthesised.

Test Plan:
- DIV=4. Write 0xA5 into an idle block → tx low 4 cycles after pop, then 1,0,1,0,0,1,0,1, then stop 1, each bit 4 cycles. busy high exactly 40 cycles; level back to 0 after the pop.
- DIV=4, FIFO_DEPTH=4. Hold wr_valid with bytes 0x01..0x06 on consecutive cycles → 0x01..0x05 accepted, level peaks at 4. 0x06 stalls with wr_ready=0 until the next pop. Six contiguous frames, 240 cycles, no idle gap between frames.
- Queue 0x11,0x22,0x33, then drop ena mid-way through frame 0x11 → 0x11 completes, tx stays 1, level=2, tx_oe=0. Raise ena → 0x22 then 0x33 transmitted.
- Assert rst_n low during data bit 3 of 0x F0 with 2 bytes queued → same cycle: tx=1, busy=0, level=0. After release, tx stays idle until a new write.
- With TT_UART_TX_PARITY_EN, DIV=4: write 0x07 → parity bit 1 after the data bits, frame 44 cycles. Write 0x03 → parity bit 0. Without the macro, 0x07 takes 40 cycles.
- With DIV=2, write 0xFF then 0x00 back to back → 20-cycle frames, contiguous. Check the correct bit pattern and start/stop timing at the minimum divisor.
